mdiv_cycle_counter: RTL and testbench
=====================================

# mdiv_cycle_counter

Parametrised, loadable up/down cycle counter with terminal-count detection and a tristate read port, used by the multiplier/divider control path to sequence iteration counts and signal completion. It extends the plain enable-gated counter register with a runtime-selectable direction, a programmable target, a wrap-or-saturate mode and a small IDLE/RUN/DONE controller that produces a one-cycle completion pulse. The tristate `out` port lets several counters share a readback bus.

## Interface
- `WIDTH`, 32: counter, load and target width in bits (min 2).
- `SATURATE`, 1: 1 = clamp at 0 / all-ones; 0 = modulo-2^WIDTH wrap.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `load`  in  1  capture `load_val` and start a run.
- `load_val`  in  WIDTH  start value.
- `target`  in  WIDTH  terminal value; sampled every cycle, not latched.
- `up`  in  1  direction: 1 = +1 per step, 0 = -1 per step.
- `count_en`  in  1  advance one step this cycle (RUN only).
- `enable_out`  in  1  drive `out`; otherwise `out` is high-Z.
- `out`  out  WIDTH  `count` when `enable_out`=1, else all bits Z.
- `count`  out  WIDTH  current counter value, always driven.
- `busy`  out  1  high in RUN.
- `done`  out  1  high for exactly one cycle (DONE state).
- `ovf`  out  1  sticky wrap/saturation flag.

## Operation
- States: IDLE (reset state), RUN, DONE. `busy` = (state==RUN), `done` = (state==DONE); both decoded from the state register.
- Priority per edge: `reset` > `load` > count step > hold.
- `load`=1 (any state): `count`<=`load_val`, `ovf`<=0; state<=DONE if `load_val`==`target`, else RUN.
- RUN, `count_en`=1, `load`=0: `count`<=next, where next = count±1 under the mode rules below; if next==`target`, state<=DONE, else stay in RUN.
- RUN, `count_en`=0: hold `count` and state.
- DONE: unconditionally -> IDLE on the next edge unless `load`=1. `count` holds and `count_en` is ignored.
- IDLE: `count` holds and `count_en` is ignored; only `load` leaves IDLE.
- Boundaries:
  - Increment at all-ones or decrement at 0 sets `ovf`<=1.
  - With SATURATE=1, `count` stays at the boundary value.
  - With SATURATE=0, `count` wraps (all-ones -> 0, 0 -> all-ones).
  - `ovf` stays set until the next `load` or `reset`.
- A target that is unreachable in the chosen direction is legal. With SATURATE=1 the counter parks at the boundary in RUN until `load`/`reset`. With SATURATE=0 it wraps and eventually hits the target.
- `up` and `target` may change mid-run and take effect on the next step.
- `out` is purely combinational from `enable_out` and `count`.

## Timing
- Reset values, visible after the first `reset` edge: `count`=0, state IDLE, `busy`=0, `done`=0, `ovf`=0. `out` = 0 if `enable_out`=1, else Z.
- `reset` mid-run aborts immediately; no `done` pulse is produced.
- Load latency: `count`=`load_val` and `busy`=1 in the cycle after the `load` edge. If `load_val`==`target`, `done`=1 in that cycle instead of `busy`.
- Step latency: one `count_en` cycle changes `count` by one LSB on the next edge.
- A load of V with direction down and target T<V, `count_en` held high: `busy` is high for V-T cycles, then `done` is high for 1 cycle, with `count`=T. `done` is followed by IDLE.
- A `load` in the DONE cycle suppresses the return to IDLE: `done` for 1 cycle, then `busy` on the next cycle.
- `out` follows `enable_out` and `count` within the same cycle (no register stage).

## Test plan
- **Reset:** assert `reset` 2 cycles with `enable_out`=1 after arbitrary activity -> `count`=0, `busy`=`done`=`ovf`=0, `out`=0. Then `enable_out`=0 -> `out`=Z on all 32 bits.
- **Down-count to completion:** `load_val`=5, `target`=0, `up`=0, `count_en`=1 continuous -> `count` 5,4,3,2,1 with `busy`=1 for 5 cycles, then `count`=0 with `done`=1 for exactly 1 cycle, then IDLE with `count` held at 0.
- **Stall and restart:** up-count from 10 to `target`=14, with `count_en` low every other cycle -> `done` appears 8 cycles after the load edge. Then reload 3 in the DONE cycle -> `done`=1 for 1 cycle, next cycle `busy`=1 and `count`=3.
- **Saturate mode** (SATURATE=1, WIDTH=8): load 254, `target`=10, `up`=1 -> `count` 255, then held at 255, `ovf`=1 stays set, `busy` stays 1. `load`=0x00 clears `ovf`.
- **Wrap mode** (SATURATE=0, WIDTH=8): load 254, `target`=1, `up`=1 -> `count` 255, 0, 1 then `done`; `ovf`=1 from the 255->0 step onward.
- **Edge cases:** load with `load_val`==`target`=7 -> `done` the next cycle, `busy` never set. `reset` asserted mid-run at `count`=3 -> `count`=0, IDLE, no `done` pulse.

Source files
------------

// File: rtl/mdiv_cycle_counter.sv
// mdiv_cycle_counter
//
// Loadable up/down cycle counter for the multiplier/divider control path.
// A load starts a run; each enabled step moves the count one LSB toward
// the (live, unlatched) target. When the target is reached, a one-cycle
// DONE state signals completion. At the range ends the count either
// saturates or wraps, depending on SATURATE. Either way, the sticky ovf flag
// is raised. A tristate read port allows several counters to share one
// readback bus.
//
// Parameters
//   WIDTH      counter / load / target width (>= 2)
//   SATURATE   1: clamp at 0 / all-ones, 0: modulo-2^WIDTH wrap
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   load        in   capture load_val and start a run (any state)
//   load_val    in   start value
//   target      in   terminal value, sampled every cycle
//   up          in   1 = count up, 0 = count down
//   count_en    in   advance one step this cycle (RUN only)
//   enable_out  in   drive out, otherwise out is high-Z
//   out         out  count when enable_out = 1, else all bits Z
//   count       out  current counter value
//   busy        out  high in RUN
//   done        out  high for the single DONE cycle
//   ovf         out  sticky wrap/saturation flag, cleared by load/reset
//
// Handshake: there is no valid/ready pair. load is a one-cycle command that
// always wins over stepping. busy/done report progress and are decoded
// straight from the state register.

module mdiv_cycle_counter #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] target,
  input  logic             up,
  input  logic             count_en,
  input  logic             enable_out,
  output tri   [WIDTH-1:0] out,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             ovf_q;

  // Candidate value for one step in the current direction.
  logic [WIDTH-1:0] step_d;
  logic             step_ovf;

  always_comb begin
    step_d   = count_q;
    step_ovf = 1'b0;
    if (up) begin
      if (&count_q) begin
        step_ovf = 1'b1;
        step_d   = SATURATE ? count_q : '0;
      end else begin
        step_d = count_q + ONE;
      end
    end else begin
      if (count_q == '0) begin
        step_ovf = 1'b1;
        step_d   = SATURATE ? count_q : '1;
      end else begin
        step_d = count_q - ONE;
      end
    end
  end

  // Priority: reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      count_q <= load_val;
      ovf_q   <= 1'b0;
      state_q <= (load_val == target) ? ST_DONE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (count_en) begin
            count_q <= step_d;
            if (step_ovf) ovf_q <= 1'b1;
            // A saturated count that is parked at a boundary never equals
            // an unreachable target, so it stays in RUN until reloaded.
            if (step_d == target) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

  // The shared-bus read port has no register stage.
  assign out = enable_out ? count_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mdiv_cycle_counter.sv
// Directed bench for mdiv_cycle_counter.
//   dut_a : WIDTH=32, SATURATE=1 (reset, down-count, stall/restart, edge cases,
//           tristate read port on a bus shared with a bench driver)
//   dut_s : WIDTH=8,  SATURATE=1 (saturation at both ends)
//   dut_w : WIDTH=8,  SATURATE=0 (wrap at both ends)
// Inputs change 1 ns after a rising edge and outputs are checked there.

module tb_mdiv_cycle_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // ---------------- stimulus signals ----------------
  logic        up         = 1'b0;
  logic        count_en   = 1'b0;
  logic        enable_out = 1'b0;

  logic        load_a = 1'b0;
  logic [31:0] lv_a   = '0;
  logic [31:0] tg_a   = '0;

  logic        load8  = 1'b0;
  logic [7:0]  lv8    = '0;
  logic [7:0]  tg_s   = '0;
  logic [7:0]  tg_w   = '0;

  // Bench-side driver on the shared readback bus.
  logic        tb_drive = 1'b0;
  logic [31:0] tb_pat   = '0;

  tri   [31:0] bus_a;
  assign bus_a = tb_drive ? tb_pat : {32{1'bz}};

  logic [31:0] count_a;
  logic        busy_a, done_a, ovf_a;

  wire  [7:0]  out_s, out_w;
  logic [7:0]  count_s, count_w;
  logic        busy_s, done_s, ovf_s;
  logic        busy_w, done_w, ovf_w;

  mdiv_cycle_counter #(.WIDTH(32), .SATURATE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .load_val(lv_a), .target(tg_a),
    .up(up), .count_en(count_en), .enable_out(enable_out),
    .out(bus_a), .count(count_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  mdiv_cycle_counter #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .load(load8), .load_val(lv8), .target(tg_s),
    .up(up), .count_en(count_en), .enable_out(enable_out),
    .out(out_s), .count(count_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
  );

  mdiv_cycle_counter #(.WIDTH(8), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .load(load8), .load_val(lv8), .target(tg_w),
    .up(up), .count_en(count_en), .enable_out(enable_out),
    .out(out_w), .count(count_w), .busy(busy_w), .done(done_w), .ovf(ovf_w)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] c,
                         input logic b, input logic d);
    check({tag, ".count"}, count_a, c);
    check({tag, ".busy"},  {31'b0, busy_a}, {31'b0, b});
    check({tag, ".done"},  {31'b0, done_a}, {31'b0, d});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Initial reset, then some arbitrary activity.
    tick(); tick();
    reset = 1'b0;
    lv_a = 32'h55; tg_a = 32'h0; up = 1'b1; count_en = 1'b1; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    tick(); tick();
    check("pre_reset.count", count_a, 32'h57);

    // Reset held two cycles with the read port enabled.
    reset = 1'b1; enable_out = 1'b1;
    tick(); tick();
    reset = 1'b0; count_en = 1'b0;
    check_a("reset", 32'h0, 1'b0, 1'b0);
    check("reset.ovf", {31'b0, ovf_a}, 32'h0);
    check("reset.out", bus_a, 32'h0);
    // Released port: only the bench driver determines the bus value.
    enable_out = 1'b0; tb_drive = 1'b1; tb_pat = 32'hFFFF_FFFF;
    #1;
    check("reset.out_z", bus_a, 32'hFFFF_FFFF);
    tb_drive = 1'b0;

    // Down-count 5 -> 0.
    lv_a = 32'd5; tg_a = 32'd0; up = 1'b0; count_en = 1'b1; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    check_a("down.load", 32'd5, 1'b1, 1'b0);
    // Read port while count is nonzero: enabled shows count, released shows
    // the bench's pattern.
    enable_out = 1'b1;
    #1;
    check("down.out_en", bus_a, 32'd5);
    enable_out = 1'b0; tb_drive = 1'b1; tb_pat = 32'h0;
    #1;
    check("down.out_z", bus_a, 32'h0);
    tb_drive = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      tick();
      check_a($sformatf("down.c%0d", i), i[31:0], 1'b1, 1'b0);
    end
    tick();
    check_a("down.done", 32'd0, 1'b0, 1'b1);
    tick();
    check_a("down.idle", 32'd0, 1'b0, 1'b0);
    tick();
    check_a("down.idle2", 32'd0, 1'b0, 1'b0);

    // Stall and restart: 10 -> 14, count_en low on odd edges after load.
    lv_a = 32'd10; tg_a = 32'd14; up = 1'b1; count_en = 1'b0; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    check_a("stall.load", 32'd10, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      count_en = (k % 2 == 0);
      tick();
      check_a($sformatf("stall.e%0d", k), 32'd10 + 32'(k / 2),
              (k != 8), (k == 8));
    end
    lv_a = 32'd3; load_a = 1'b1; count_en = 1'b0;
    tick();
    load_a = 1'b0;
    check_a("restart", 32'd3, 1'b1, 1'b0);

    // load_val == target: straight to DONE, busy never set.
    lv_a = 32'd7; tg_a = 32'd7; load_a = 1'b1; count_en = 1'b1;
    tick();
    load_a = 1'b0;
    check_a("eq.done", 32'd7, 1'b0, 1'b1);
    tick();
    check_a("eq.idle", 32'd7, 1'b0, 1'b0);

    // Reset mid-run at count 3 aborts without a done pulse.
    lv_a = 32'd0; tg_a = 32'd9; up = 1'b1; count_en = 1'b1; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    tick(); tick(); tick();
    check_a("abort.pre", 32'd3, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_a("abort.reset", 32'd0, 1'b0, 1'b0);
    tick();
    check_a("abort.after", 32'd0, 1'b0, 1'b0);

    // Upper boundary: saturate (target 10) vs wrap (target 1), load 254 up.
    lv8 = 8'd254; tg_s = 8'd10; tg_w = 8'd1; up = 1'b1; count_en = 1'b1;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    check("up.s.c254", {24'b0, count_s}, 32'd254);
    check("up.w.c254", {24'b0, count_w}, 32'd254);
    tick();
    check("up.s.c255", {24'b0, count_s}, 32'd255);
    check("up.s.ovf0", {31'b0, ovf_s}, 32'd0);
    check("up.w.c255", {24'b0, count_w}, 32'd255);
    check("up.w.ovf0", {31'b0, ovf_w}, 32'd0);
    tick();
    check("up.s.hold", {24'b0, count_s}, 32'd255);
    check("up.s.ovf1", {31'b0, ovf_s}, 32'd1);
    check("up.w.c0",   {24'b0, count_w}, 32'd0);
    check("up.w.ovf1", {31'b0, ovf_w}, 32'd1);
    check("up.w.busy", {31'b0, busy_w}, 32'd1);
    tick();
    check("up.s.hold2", {24'b0, count_s}, 32'd255);
    check("up.s.busy",  {31'b0, busy_s}, 32'd1);
    check("up.w.c1",    {24'b0, count_w}, 32'd1);
    check("up.w.done",  {31'b0, done_w}, 32'd1);
    tick();
    check("up.s.sticky", {31'b0, ovf_s}, 32'd1);
    check("up.s.busy2",  {31'b0, busy_s}, 32'd1);
    check("up.w.idle",   {30'b0, busy_w, done_w}, 32'd0);
    check("up.w.sticky", {31'b0, ovf_w}, 32'd1);
    lv8 = 8'd0; load8 = 1'b1; count_en = 1'b0;
    tick();
    load8 = 1'b0;
    check("up.s.clr", {31'b0, ovf_s}, 32'd0);
    check("up.s.c0",  {24'b0, count_s}, 32'd0);

    // Lower boundary: load 1, count down toward an unreachable 200.
    lv8 = 8'd1; tg_s = 8'd200; tg_w = 8'd200; up = 1'b0; count_en = 1'b1;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    tick();
    check("dn.s.c0",   {24'b0, count_s}, 32'd0);
    check("dn.s.ovf0", {31'b0, ovf_s}, 32'd0);
    tick();
    check("dn.s.hold", {24'b0, count_s}, 32'd0);
    check("dn.s.ovf1", {31'b0, ovf_s}, 32'd1);
    check("dn.s.busy", {31'b0, busy_s}, 32'd1);
    check("dn.w.c255", {24'b0, count_w}, 32'd255);
    check("dn.w.ovf1", {31'b0, ovf_w}, 32'd1);
    tick();
    check("dn.w.c254", {24'b0, count_w}, 32'd254);
    count_en = 1'b0;

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
